mem_bank_mp: RTL and testbench

//   Parametrised multi-port, byte-addressed transparent memory bank.

---
 rtl/mem_bank_pkg.sv | 22 ++
 rtl/mem_bank_clr_ctrl.sv | 53 +++++
 rtl/mem_bank_mp.sv | 111 +++++++++++
 tb/tb_mem_bank_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared types and byte-lane helpers for the multi-port byte-addressed memory bank.
package mem_bank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction

   // Byte k of a big-endian word (k = 0 is the MSB, stored at addr).
   function automatic int be_idx(input int nb, input int k);
      return nb - 1 - k;
   endfunction

   function automatic int lane_lsb(input int nb, input int k);
      return 8 * (nb - 1 - k);
   endfunction

endpackage

// File: rtl/mem_bank_clr_ctrl.sv
// Sequential clear engine: walks the array CLR_BPC bytes per cycle and holds busy while running.
//
// state | meaning
// IDLE  | array usable, waiting for clr_req
// CLEAR | zeroing the block at clr_ptr each cycle; writes and reads are blocked
module mem_bank_clr_ctrl
   import mem_bank_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int CLR_BPC = 64
) (
   input  logic              clk,
   input  logic              rstz,
   input  logic              clr_req,
   output logic              busy,
   output logic [ADDR_W-1:0] clr_ptr
);

   localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(CLR_BPC);
   // CLR_BPC is a power of two, so the last block base is DEPTH - CLR_BPC.
   localparam logic [ADDR_W-1:0] LAST_PTR = ~ADDR_W'(CLR_BPC - 1);

   clr_state_t        state, state_nxt;
   logic [ADDR_W-1:0] ptr_nxt;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = clr_ptr;
      case (state)
         IDLE: begin
            if (clr_req) state_nxt = CLEAR;
         end
         CLEAR: begin
            ptr_nxt = clr_ptr + PTR_STEP;
            if (clr_ptr == LAST_PTR) state_nxt = IDLE;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   assign busy = (state == CLEAR);

endmodule

// File: rtl/mem_bank_mp.sv
// Multi-port big-endian byte-addressed memory bank with lane-priority writes and a clear engine.
// Define MEM_BANK_RDREG_EN for registered read data (1-cycle latency); default is combinational.
module mem_bank_mp
   import mem_bank_pkg::*;
#(
   parameter int NPORTS  = 2,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int CLR_BPC = 64
) (
   input  logic                           clk,
   input  logic                           rstz,
   input  logic                           clr_req,
   input  logic [NPORTS*ADDR_W-1:0]       addr,
   input  logic [NPORTS*DATA_W-1:0]       wdata,
   input  logic [NPORTS-1:0]              we,
   input  logic [NPORTS*(DATA_W/8)-1:0]   be,
   output logic [NPORTS*DATA_W-1:0]       rdata,
   output logic                           busy,
   output logic [NPORTS-1:0]              wr_collide,
   inout  wire                            dvdd,
   inout  wire                            dgnd
);

   localparam int NB    = bytes_per_word(DATA_W);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] lane_addr [NPORTS][NB];
   logic [7:0]        lane_data [NPORTS][NB];
   logic [NB-1:0]     lane_en [NPORTS];
   logic [NPORTS-1:0] collide;
   logic [NPORTS*DATA_W-1:0] rd_word;
   logic [ADDR_W-1:0] clr_ptr;
   logic              unused_pwr;

   assign unused_pwr = dvdd ^ dgnd;

   mem_bank_clr_ctrl #(
      .ADDR_W  (ADDR_W),
      .CLR_BPC (CLR_BPC)
   ) u_clr_ctrl (
      .clk     (clk),
      .rstz    (rstz),
      .clr_req (clr_req),
      .busy    (busy),
      .clr_ptr (clr_ptr)
   );

   // Lane k of each port is byte k of its word, counted from the MSB; address wraps mod DEPTH.
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         for (int k = 0; k < NB; k++) begin
            lane_addr[p][k] = addr[p*ADDR_W +: ADDR_W] + ADDR_W'(k);
            lane_data[p][k] = wdata[p*DATA_W + lane_lsb(NB, k) +: 8];
            lane_en[p][k]   = we[p] & be[p*NB + be_idx(NB, k)];
         end
      end
   end

   always_comb begin
      collide = '0;
      for (int p = 1; p < NPORTS; p++) begin
         for (int k = 0; k < NB; k++) begin
            for (int q = 0; q < p; q++) begin
               for (int j = 0; j < NB; j++) begin
                  if (lane_en[p][k] && lane_en[q][j] && (lane_addr[p][k] == lane_addr[q][j]))
                     collide[p] = 1'b1;
               end
            end
         end
      end
   end

   // Lower-index ports are scheduled last, so their bytes win any overlap.
   always_ff @(posedge clk) begin
      if (busy) begin
         for (int i = 0; i < CLR_BPC; i++)
            mem[clr_ptr + ADDR_W'(i)] <= '0;
      end else begin
         for (int p = NPORTS - 1; p >= 0; p--) begin
            for (int k = 0; k < NB; k++) begin
               if (lane_en[p][k]) mem[lane_addr[p][k]] <= lane_data[p][k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) wr_collide <= '0;
      else       wr_collide <= busy ? '0 : collide;
   end

   always_comb begin
      rd_word = '0;
      for (int p = 0; p < NPORTS; p++) begin
         for (int k = 0; k < NB; k++)
            rd_word[p*DATA_W + lane_lsb(NB, k) +: 8] = mem[lane_addr[p][k]];
      end
   end

`ifdef MEM_BANK_RDREG_EN
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) rdata <= '0;
      else       rdata <= busy ? '0 : rd_word;
   end
`else
   assign rdata = busy ? '0 : rd_word;
`endif

endmodule

// File: tb/tb_mem_bank_mp.sv
// Self-checking bench for mem_bank_mp: directed cases plus random writes against a byte-array model.
module tb_mem_bank_mp;

   localparam int NP      = 2;
   localparam int DW      = 16;
   localparam int AW      = 8;
   localparam int BPC     = 64;
   localparam int NB      = DW / 8;
   localparam int DEPTH   = 1 << AW;
   localparam int CLR_CYC = DEPTH / BPC;

   logic              clk = 1'b0;
   logic              rstz = 1'b0;
   logic              clr_req = 1'b0;
   logic [NP*AW-1:0]  addr = '0;
   logic [NP*DW-1:0]  wdata = '0;
   logic [NP-1:0]     we = '0;
   logic [NP*NB-1:0]  be = '0;
   logic [NP*DW-1:0]  rdata;
   logic              busy;
   logic [NP-1:0]     wr_collide;
   wire               dvdd = 1'b1;
   wire               dgnd = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [7:0]       model_mem [DEPTH];
   int               busy_left;
   logic [NP-1:0]    exp_col;
   logic [NP*DW-1:0] last_rd;
   logic [NP-1:0]    last_col;

   always #5 clk = ~clk;

   mem_bank_mp #(
      .NPORTS  (NP),
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .CLR_BPC (BPC)
   ) dut (
      .clk        (clk),
      .rstz       (rstz),
      .clr_req    (clr_req),
      .addr       (addr),
      .wdata      (wdata),
      .we         (we),
      .be         (be),
      .rdata      (rdata),
      .busy       (busy),
      .wr_collide (wr_collide),
      .dvdd       (dvdd),
      .dgnd       (dgnd)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
   endtask

   function automatic logic [NP*DW-1:0] model_read(input logic [NP*AW-1:0] a);
      logic [NP*DW-1:0] r;
      int base;
      r = '0;
      if (busy_left > 0) return r;
      for (int p = 0; p < NP; p++) begin
         base = int'(a[p*AW +: AW]);
         for (int k = 0; k < NB; k++)
            r[p*DW + (NB-1-k)*8 +: 8] = model_mem[(base + k) % DEPTH];
      end
      return r;
   endfunction

   // One clock: drive inputs at negedge, check read (pre-write contents), update model at the edge,
   // then check collision flags and busy after the edge.
   task automatic step(input logic [NP-1:0] s_we, input logic [NP*NB-1:0] s_be,
                       input logic [NP*AW-1:0] s_addr, input logic [NP*DW-1:0] s_wdata,
                       input logic s_clr);
      logic [NP*DW-1:0] exp_rd;
      int owner [DEPTH];
      int a;
      @(negedge clk);
      we = s_we; be = s_be; addr = s_addr; wdata = s_wdata; clr_req = s_clr;
      exp_rd = model_read(s_addr);
`ifndef MEM_BANK_RDREG_EN
      #2;
      chk("rdata", rdata, exp_rd);
`endif
      @(posedge clk);
      exp_col = '0;
      if (busy_left > 0) begin
         busy_left--;
      end else begin
         for (int i = 0; i < DEPTH; i++) owner[i] = -1;
         for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < NB; k++) begin
               if (s_we[p] && s_be[p*NB + NB-1-k]) begin
                  a = (int'(s_addr[p*AW +: AW]) + k) % DEPTH;
                  if (owner[a] >= 0) exp_col[p] = 1'b1;
                  else begin
                     owner[a] = p;
                     model_mem[a] = s_wdata[p*DW + (NB-1-k)*8 +: 8];
                  end
               end
            end
         end
         if (s_clr) begin
            busy_left = CLR_CYC;
            clear_model();
         end
      end
      #1;
`ifdef MEM_BANK_RDREG_EN
      chk("rdata_reg", rdata, exp_rd);
`endif
      chk("wr_collide", wr_collide, exp_col);
      chk("busy", busy, busy_left > 0);
      last_rd  = rdata;
      last_col = wr_collide;
   endtask

   task automatic rand_step(input int allow_clr);
      logic [NP-1:0]    r_we;
      logic [NP*NB-1:0] r_be;
      logic [NP*AW-1:0] r_addr;
      logic [NP*DW-1:0] r_wdata;
      logic             r_clr;
      r_we    = NP'($urandom_range(0, (1 << NP) - 1));
      r_be    = (NP*NB)'($urandom_range(0, (1 << (NP*NB)) - 1));
      r_wdata = (NP*DW)'($urandom);
      for (int p = 0; p < NP; p++) begin
         if ($urandom_range(0, 1) == 1) r_addr[p*AW +: AW] = AW'($urandom_range(64, 67));
         else                           r_addr[p*AW +: AW] = AW'($urandom);
      end
      r_clr = (allow_clr != 0) && ($urandom_range(0, 49) == 0);
      step(r_we, r_be, r_addr, r_wdata, r_clr);
   endtask

   task automatic idle(input logic [NP*AW-1:0] a);
      step('0, '0, a, '0, 1'b0);
   endtask

   initial begin
      int n;
      busy_left = CLR_CYC;
      exp_col   = '0;
      clear_model();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b1);
      chk("rst_collide", wr_collide, '0);
      chk("rst_rdata", rdata, '0);
      rstz = 1'b1;

      // Busy lasts exactly DEPTH/CLR_BPC cycles after release
      n = 0;
      while (busy && n < 10) begin
         idle(NP*AW'($urandom));
         n++;
      end
      chk("t1_busy_len", n, CLR_CYC);
      idle({8'h80, 8'h00});
      chk("t1_zero", last_rd, '0);

      // Big-endian write
      step(2'b01, 4'b0011, {8'h00, 8'h10}, {16'h0000, 16'hA55A}, 1'b0);
      idle({8'h10, 8'h10});
      chk("t2_p0", last_rd[15:0], 16'hA55A);
      chk("t2_p1", last_rd[31:16], 16'hA55A);
      idle({8'h11, 8'h10});
      chk("t2_unaligned", last_rd[31:16], 16'h5A00);

      // Byte enable with address wrap
      step(2'b01, 4'b0001, {8'h00, 8'hFF}, {16'h0000, 16'h1234}, 1'b0);
      idle({8'h00, 8'hFF});
      chk("t3_wrap_read", last_rd[15:0], 16'h0034);
      chk("t3_byte0", last_rd[31:16], 16'h3400);

      // Collision: port0 wins the shared byte
      step(2'b11, 4'b1111, {8'h21, 8'h20}, {16'h2222, 16'h1111}, 1'b0);
      chk("t4_collide", last_col, 2'b10);
      idle({8'h22, 8'h20});
      chk("t4_p0", last_rd[15:0], 16'h1111);
      chk("t4_p1", last_rd[31:16], 16'h2200);
      chk("t4_pulse", last_col, 2'b00);

      // Random traffic against the model
      for (int i = 0; i < 200; i++) rand_step(1);
      n = 0;
      while (busy && n < 10) begin
         idle('0);
         n++;
      end

      // Writes during clear are dropped, array ends all zero
      for (int i = 0; i < 20; i++) rand_step(0);
      step('0, '0, '0, '0, 1'b1);
      for (int i = 0; i < CLR_CYC; i++) begin
         rand_step(0);
         chk("t5_busy_rd", last_rd, '0);
      end
      chk("t5_busy_done", busy, 1'b0);
      for (int i = 0; i < DEPTH / 2; i++) begin
         idle({AW'(2*i + 1), AW'(2*i)});
         chk("t5_zero", last_rd, '0);
      end

      // Reset mid-clear restarts the full clear
      for (int i = 0; i < 10; i++) rand_step(0);
      step('0, '0, '0, '0, 1'b1);
      idle('0);
      idle('0);
      @(negedge clk);
      we = '0; clr_req = 1'b0; rstz = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 1'b1);
      chk("t6_rst_rdata", rdata, '0);
      chk("t6_rst_collide", wr_collide, '0);
      repeat (2) @(posedge clk);
      #1;
      rstz = 1'b1;
      busy_left = CLR_CYC;
      clear_model();
      n = 0;
      while (busy && n < 10) begin
         rand_step(0);
         n++;
      end
      chk("t6_busy_len", n, CLR_CYC);
      for (int i = 0; i < 40; i++) rand_step(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
